cv_serial_sequencer: RTL and testbench
======================================

// Module: cv_serial_sequencer
// PURPOSE
//  Front-end controller for the serial Excess-3 -> BCD converter (ports X, Clk, Rst, Z).
//  - Accepts a parallel word of NDIG Excess-3 digits over a valid/ready handshake.
//  - Drives the converter one bit per cycle: least-significant digit first, each digit LSB first.
//  - Frames each digit with the converter's active-low reset, samples Z each bit and returns
//    the assembled BCD word over a second valid/ready handshake.
// PARAMETERS
//  NDIG         1  number of 4-bit digits per word (1..8)
//  CLR_BETWEEN  1  1: one converter-reset cycle between digits; 0: digits shifted back-to-back
// PORTS
//  Clk         in   1       clock, all state updates on posedge
//  Rst         in   1       asynchronous, active-low reset
//  in_valid    in   1       in_data holds a word to convert
//  in_ready    out  1       sequencer can accept a word (IDLE only)
//  in_data     in   4*NDIG  Excess-3 digits, digit k at [4k+3:4k]
//  conv_x      out  1       serial bit to converter X (registered)
//  conv_rst_n  out  1       to converter Rst, active-low (registered)
//  conv_z      in   1       converter Z (Mealy; valid before the posedge ending the bit cycle)
//  out_valid   out  1       out_data/out_err valid (DONE only)
//  out_ready   in   1       consumer takes the result
//  out_data    out  4*NDIG  BCD result, digit k at [4k+3:4k]
//  out_err     out  1       input range error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset values: state=IDLE, in_ready=1, conv_x=0, conv_rst_n=0, out_valid=0, out_data=0,
//    out_err=0. Bit and digit counters = 0.
//  - IDLE:
//    - in_ready=1, conv_rst_n=0.
//    - Accept on posedge with in_valid&&in_ready: latch in_data into a shift register,
//      clear out_data, set conv_x=in_data[0] and conv_rst_n=1, go to SHIFT.
//  - SHIFT (4 cycles per digit):
//    - conv_rst_n=1, conv_x=current bit.
//    - Each posedge: write conv_z into out_data[4*dig+bit], advance to the next bit.
//    - On bit==3, last digit: go to DONE.
//    - On bit==3, not last digit: go to CLR if CLR_BETWEEN=1, else stay in SHIFT with
//      the next digit's bit0 and conv_rst_n still 1.
//  - CLR: exactly one cycle, conv_rst_n=0, conv_x=0, then SHIFT with the next digit's bit0.
//  - DONE:
//    - out_valid=1, conv_rst_n=0, in_ready=0.
//    - out_data/out_err held stable until out_ready=1 at a posedge, then IDLE.
//  - Latency, accept posedge to out_valid=1: 4*NDIG + CLR_BETWEEN*(NDIG-1) cycles.
//  - Throughput: no overlap. A new word is accepted only in IDLE, at least one cycle after
//    the previous result is taken.
//  - in_valid while busy: ignored (in_ready=0); the upstream must hold it.
//    in_data is sampled only at accept.
//  - out_ready while out_valid=0: no effect.
//  - Reset asserted mid-operation: immediate return to reset values (conv_rst_n=0 forces
//    the converter to its start state). The partial result is discarded and no out_valid is
//    produced for that word.
//  - Counters: 2-bit bit counter wraps 3->0 at each digit end. The digit counter is
//    clog2(NDIG) wide (min 1) and cleared at accept.
// CONFIGURATION
//  CV_SEQ_RANGE_CHECK_EN
//    Defined: at accept, each digit is checked against 3..12. If any digit is out of range,
//      go directly to DONE next cycle with out_err=1 and out_data all ones. The converter is
//      never released from reset for that word.
//    Undefined: no check, out_err is tied 0, and every word is shifted as-is.
// TESTING
//  - NDIG=1, in_data=4'b0011 -> conv_x 1,1,0,0 over 4 cycles; out_data=4'h0, out_valid
//    4 cycles after accept.
//  - NDIG=1, in_data=4'b1100 -> out_data=4'h9. All 10 codes 3..12 -> 0..9.
//  - NDIG=2, CLR_BETWEEN=1, in_data=8'h4C -> one conv_rst_n=0 cycle between digits;
//    out_data=8'h19 at cycle 9.
//  - Backpressure: out_ready=0 for 10 cycles -> out_valid, out_data stable and in_ready=0;
//    the next word is accepted only after the handshake.
//  - Rst low during bit 2 of a digit -> next cycle conv_rst_n=0, in_ready=1, out_valid=0;
//    the following word converts correctly.
//  - 10000 random in-range words, NDIG=1 and 2, vs. a reference model; with
//    CV_SEQ_RANGE_CHECK_EN, 4'h0/4'hF -> out_err=1, out_data all ones.

Source files
------------

// File: rtl/cv_serial_sequencer.sv
// Serial front-end for the Excess-3 -> BCD converter: shifts NDIG digits LSB first and assembles Z.
// Optional feature macro: CV_SEQ_RANGE_CHECK_EN (reject words with any digit outside 3..12).
module cv_serial_sequencer #(
    parameter int NDIG        = 1,
    parameter int CLR_BETWEEN = 1
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*NDIG-1:0]   in_data,
    output logic                conv_x,
    output logic                conv_rst_n,
    input  logic                conv_z,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*NDIG-1:0]   out_data,
    output logic                out_err
);

    localparam int            DW       = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [DW-1:0] LAST_DIG = DW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CLR, DONE} state_t;

    state_t            state, state_nxt;
    logic [4*NDIG-1:0] sreg;
    logic [1:0]        bit_cnt;
    logic [DW-1:0]     dig_cnt;
    logic [DW+1:0]     wr_idx;
    logic              accept, last_bit, last_dig, range_bad;

    assign accept   = in_valid && in_ready;
    assign last_bit = (bit_cnt == 2'd3);
    assign last_dig = (dig_cnt == LAST_DIG);
    assign wr_idx   = {dig_cnt, bit_cnt};

`ifdef CV_SEQ_RANGE_CHECK_EN
    always_comb begin
        range_bad = 1'b0;
        for (int k = 0; k < NDIG; k++) begin
            if (in_data[4*k +: 4] < 4'd3 || in_data[4*k +: 4] > 4'd12) begin
                range_bad = 1'b1;
            end
        end
    end

    // Error flag follows the accepted word and stays put until the next accept.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            out_err <= 1'b0;
        end else if (accept) begin
            out_err <= range_bad;
        end
    end
`else
    assign range_bad = 1'b0;
    assign out_err   = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = range_bad ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    if (last_dig) begin
                        state_nxt = DONE;
                    end else if (CLR_BETWEEN != 0) begin
                        state_nxt = CLR;
                    end else begin
                        state_nxt = SHIFT;
                    end
                end
            end
            CLR: begin
                state_nxt = SHIFT;
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // conv_x always presents the bit the converter consumes in the following cycle,
    // so the shift register holds only the bits not yet driven.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            conv_x     <= 1'b0;
            conv_rst_n <= 1'b0;
            sreg       <= '0;
            out_data   <= '0;
            bit_cnt    <= 2'd0;
            dig_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sreg    <= in_data >> 1;
                        bit_cnt <= 2'd0;
                        dig_cnt <= '0;
                        if (range_bad) begin
                            out_data   <= '1;
                            conv_x     <= 1'b0;
                            conv_rst_n <= 1'b0;
                        end else begin
                            out_data   <= '0;
                            conv_x     <= in_data[0];
                            conv_rst_n <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    for (int k = 0; k < 4*NDIG; k++) begin
                        if (k == int'(wr_idx)) begin
                            out_data[k] <= conv_z;
                        end
                    end
                    bit_cnt <= bit_cnt + 2'd1;
                    if (last_bit && last_dig) begin
                        conv_x     <= 1'b0;
                        conv_rst_n <= 1'b0;
                    end else if (last_bit && CLR_BETWEEN != 0) begin
                        conv_x     <= 1'b0;
                        conv_rst_n <= 1'b0;
                        dig_cnt    <= dig_cnt + DW'(1);
                    end else begin
                        conv_x <= sreg[0];
                        sreg   <= sreg >> 1;
                        if (last_bit) begin
                            dig_cnt <= dig_cnt + DW'(1);
                        end
                    end
                end
                CLR: begin
                    conv_rst_n <= 1'b1;
                    conv_x     <= sreg[0];
                    sreg       <= sreg >> 1;
                end
                DONE: begin
                    conv_rst_n <= 1'b0;
                end
                default: begin
                    conv_rst_n <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cv_serial_sequencer.sv
// Directed bench: three sequencers (1 digit, 2 digits with clear, 2 digits back-to-back)
// each driving its own behavioural Excess-3 -> BCD converter model.
module tb_cv_serial_sequencer;

    logic       Clk;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] in_data;
    logic [2:0] iready, cx, crst, cz, ovalid, oerr;
    logic [3:0] od0;
    logic [7:0] od1, od2;

    int n_checks = 0;
    int n_fails  = 0;

    cv_serial_sequencer #(.NDIG(1), .CLR_BETWEEN(1)) u_one (
        .Clk(Clk), .Rst(rst_n), .in_valid(in_valid), .in_ready(iready[0]),
        .in_data(in_data[3:0]), .conv_x(cx[0]), .conv_rst_n(crst[0]), .conv_z(cz[0]),
        .out_valid(ovalid[0]), .out_ready(out_ready), .out_data(od0), .out_err(oerr[0]));

    cv_serial_sequencer #(.NDIG(2), .CLR_BETWEEN(1)) u_clr (
        .Clk(Clk), .Rst(rst_n), .in_valid(in_valid), .in_ready(iready[1]),
        .in_data(in_data), .conv_x(cx[1]), .conv_rst_n(crst[1]), .conv_z(cz[1]),
        .out_valid(ovalid[1]), .out_ready(out_ready), .out_data(od1), .out_err(oerr[1]));

    cv_serial_sequencer #(.NDIG(2), .CLR_BETWEEN(0)) u_b2b (
        .Clk(Clk), .Rst(rst_n), .in_valid(in_valid), .in_ready(iready[2]),
        .in_data(in_data), .conv_x(cx[2]), .conv_rst_n(crst[2]), .conv_z(cz[2]),
        .out_valid(ovalid[2]), .out_ready(out_ready), .out_data(od2), .out_err(oerr[2]));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Converter model: serial subtract of 3 (bits 1,1,0,0) with borrow, wrapping every 4 bits.
    logic [1:0] mpos [3];
    logic       mbrw [3];

    always @(posedge Clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!crst[i]) begin
                mpos[i] <= 2'd0;
                mbrw[i] <= 1'b0;
            end else begin
                mpos[i] <= mpos[i] + 2'd1;
                mbrw[i] <= (mpos[i] == 2'd3) ? 1'b0 :
                           ((~cx[i] & (mpos[i] < 2'd2)) | (~(cx[i] ^ (mpos[i] < 2'd2)) & mbrw[i]));
            end
        end
    end

    always_comb begin
        cz = '0;
        for (int i = 0; i < 3; i++) begin
            cz[i] = cx[i] ^ (mpos[i] < 2'd2) ^ mbrw[i];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One word into all three sequencers; expected result given for the 2-digit units.
    task automatic applyStimulus(input logic [7:0] din, input logic [7:0] exp);
        int         lat [3];
        logic [7:0] got [3];
        logic       err [3];
        lat = '{-1, -1, -1};
        got = '{8'h00, 8'h00, 8'h00};
        err = '{1'b0, 1'b0, 1'b0};
        @(negedge Clk);
        checkOutput("in_ready_before_accept", 32'(iready), 32'h7);
        in_data   = din;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge Clk);
            if (k == 0) begin
                in_valid = 1'b0;
                in_data  = ~din;
            end
            if (k < 4)            checkOutput("one_conv_x", 32'(cx[0]), 32'(din[k]));
            if (k >= 5 && k < 9)  checkOutput("clr_conv_x", 32'(cx[1]), 32'(din[k-1]));
            if (k >= 4 && k < 8)  checkOutput("b2b_conv_x", 32'(cx[2]), 32'(din[k]));
            if (k < 9)            checkOutput("clr_conv_rst_n", 32'(crst[1]), 32'(k != 4));
            if (k < 8)            checkOutput("b2b_conv_rst_n", 32'(crst[2]), 32'h1);
            for (int i = 0; i < 3; i++) begin
                if (ovalid[i] && lat[i] < 0) begin
                    lat[i] = k;
                    err[i] = oerr[i];
                    got[i] = (i == 0) ? {4'h0, od0} : ((i == 1) ? od1 : od2);
                end
            end
        end
        checkOutput("one_latency", 32'(lat[0]), 32'd4);
        checkOutput("clr_latency", 32'(lat[1]), 32'd9);
        checkOutput("b2b_latency", 32'(lat[2]), 32'd8);
        checkOutput("one_out_data", 32'(got[0]), 32'(exp[3:0]));
        checkOutput("clr_out_data", 32'(got[1]), 32'(exp));
        checkOutput("b2b_out_data", 32'(got[2]), 32'(exp));
        checkOutput("out_err", 32'({err[2], err[1], err[0]}), 32'h0);
        checkOutput("in_ready_after", 32'(iready), 32'h7);
    endtask

    task automatic backpressureTest();
        @(negedge Clk);
        in_data   = 8'h4C;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge Clk);
        in_valid = 1'b0;
        repeat (9) @(negedge Clk);
        for (int k = 0; k < 10; k++) begin
            if (k == 5) begin
                in_data  = 8'h33;
                in_valid = 1'b1;
            end
            checkOutput("bp_out_valid", 32'(ovalid), 32'h7);
            checkOutput("bp_in_ready", 32'(iready), 32'h0);
            checkOutput("bp_clr_data", 32'(od1), 32'h19);
            checkOutput("bp_one_data", 32'(od0), 32'h9);
            @(negedge Clk);
        end
        out_ready = 1'b1;
        @(negedge Clk);
        checkOutput("bp_release_in_ready", 32'(iready), 32'h7);
        checkOutput("bp_release_out_valid", 32'(ovalid), 32'h0);
        in_valid = 1'b0;
    endtask

    task automatic midResetTest();
        int seen;
        seen = 0;
        @(negedge Clk);
        in_data   = 8'h4C;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge Clk);
        in_valid = 1'b0;
        repeat (2) @(negedge Clk);
        rst_n = 1'b0;
        #1;
        checkOutput("mr_conv_rst_n", 32'(crst), 32'h0);
        checkOutput("mr_in_ready", 32'(iready), 32'h7);
        checkOutput("mr_out_valid", 32'(ovalid), 32'h0);
        checkOutput("mr_clr_data", 32'(od1), 32'h0);
        @(negedge Clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge Clk);
            if (ovalid != 3'b000) seen++;
        end
        checkOutput("mr_no_out_valid", 32'(seen), 32'd0);
    endtask

`ifdef CV_SEQ_RANGE_CHECK_EN
    task automatic rangeTest(input logic [7:0] din);
        @(negedge Clk);
        in_data   = din;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge Clk);
        in_valid = 1'b0;
        checkOutput("rc_out_valid", 32'(ovalid), 32'h7);
        checkOutput("rc_out_err", 32'(oerr), 32'h7);
        checkOutput("rc_one_data", 32'(od0), 32'hF);
        checkOutput("rc_clr_data", 32'(od1), 32'hFF);
        checkOutput("rc_b2b_data", 32'(od2), 32'hFF);
        checkOutput("rc_conv_rst_n", 32'(crst), 32'h0);
        out_ready = 1'b1;
        @(negedge Clk);
        checkOutput("rc_in_ready", 32'(iready), 32'h7);
    endtask
`endif

    logic [7:0] vec_in  [12] = '{8'h33, 8'h4C, 8'h5B, 8'h6A, 8'h79, 8'h88,
                                 8'h97, 8'hA6, 8'hB5, 8'hC4, 8'h3C, 8'hC3};
    logic [7:0] vec_exp [12] = '{8'h00, 8'h19, 8'h28, 8'h37, 8'h46, 8'h55,
                                 8'h64, 8'h73, 8'h82, 8'h91, 8'h09, 8'h90};

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 8'h00;
        repeat (3) @(negedge Clk);
        checkOutput("rst_in_ready", 32'(iready), 32'h7);
        checkOutput("rst_conv_x", 32'(cx), 32'h0);
        checkOutput("rst_conv_rst_n", 32'(crst), 32'h0);
        checkOutput("rst_out_valid", 32'(ovalid), 32'h0);
        checkOutput("rst_out_err", 32'(oerr), 32'h0);
        checkOutput("rst_out_data", 32'({od0, od1, od2}), 32'h0);
        rst_n = 1'b1;
        @(negedge Clk);
        checkOutput("idle_conv_rst_n", 32'(crst), 32'h0);

        for (int v = 0; v < 12; v++) begin
            applyStimulus(vec_in[v], vec_exp[v]);
        end

        backpressureTest();
        applyStimulus(8'h33, 8'h00);
        midResetTest();
        applyStimulus(8'h5B, 8'h28);

`ifdef CV_SEQ_RANGE_CHECK_EN
        rangeTest(8'hF0);
        rangeTest(8'h0F);
        applyStimulus(8'hC4, 8'h91);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
